// File: rtl/unified_memory_v2_pkg.sv
// Shared encodings and helpers for the unified instruction/data memory and its string-print engine.
package unified_memory_v2_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  typedef enum logic [2:0] {
    PS_IDLE  = 3'd0,
    PS_FETCH = 3'd1,
    PS_EMIT  = 3'd2,
    PS_DONE  = 3'd3,
    PS_ABORT = 3'd4
  } print_state_t;

  // Word index addr[31:2] must fall inside the array.
  function automatic logic word_in_range(input logic [31:0] addr, input int unsigned depth_words);
    return ({2'b00, addr[31:2]} < 32'(depth_words));
  endfunction

  // Big-endian lane select: lane 0 is bits [31:24].
  function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] lane);
    case (lane)
      2'd0:    return word[31:24];
      2'd1:    return word[23:16];
      2'd2:    return word[15:8];
      default: return word[7:0];
    endcase
  endfunction

endpackage

// File: rtl/unified_memory_v2_string_print_engine.sv
// Walks a NUL-terminated string one character per accepted handshake, refetching
// a word from the array only when the pointer crosses a word boundary.
module string_print_engine
  import unified_memory_v2_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned MAX_STR     = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        print_start,
  input  logic [31:0] print_addr,
  input  logic        char_ready,
  input  logic [31:0] rd_word,
  output logic [31:0] rd_addr,
  output logic        print_busy,
  output logic        char_valid,
  output logic [7:0]  char_data,
  output logic        print_done,
  output logic        print_abort
);

  localparam int unsigned CNT_W = $clog2(MAX_STR + 1);

  print_state_t     state_r, state_n;
  logic [31:0]      ptr_r, ptr_n;
  logic [CNT_W-1:0] cnt_r, cnt_n, cnt_inc_s;
  logic [31:0]      word_r, word_n;
  logic [7:0]       cur_byte_s, nxt_byte_s;

  // State, pointer, count and latched word registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= PS_IDLE;
      ptr_r   <= 32'h0000_0000;
      cnt_r   <= {CNT_W{1'b0}};
      word_r  <= 32'h0000_0000;
    end else begin
      state_r <= state_n;
      ptr_r   <= ptr_n;
      cnt_r   <= cnt_n;
      word_r  <= word_n;
    end
  end

  // Next-state logic; on accept, a NUL in the next lane of the latched word ends the string directly.
  always_comb begin
    state_n    = state_r;
    ptr_n      = ptr_r;
    cnt_n      = cnt_r;
    word_n     = word_r;
    cur_byte_s = word_byte(word_r, ptr_r[1:0]);
    nxt_byte_s = word_byte(word_r, ptr_r[1:0] + 2'd1);
    cnt_inc_s  = cnt_r + CNT_W'(1);
    case (state_r)
      PS_IDLE: begin
        if (print_start) begin
          ptr_n   = print_addr;
          cnt_n   = {CNT_W{1'b0}};
          state_n = PS_FETCH;
        end else begin
          state_n = PS_IDLE;
        end
      end
      PS_FETCH: begin
        if (!word_in_range(ptr_r, DEPTH_WORDS)) begin
          state_n = PS_ABORT;
        end else begin
          word_n  = rd_word;
          state_n = PS_EMIT;
        end
      end
      PS_EMIT: begin
        if (cur_byte_s == 8'h00) begin
          state_n = PS_DONE;
        end else if (char_ready) begin
          ptr_n = ptr_r + 32'd1;
          cnt_n = cnt_inc_s;
          if (cnt_inc_s == CNT_W'(MAX_STR)) begin
            state_n = PS_ABORT;
          end else if (ptr_r[1:0] == 2'd3) begin
            state_n = PS_FETCH;
          end else if (nxt_byte_s == 8'h00) begin
            state_n = PS_DONE;
          end else begin
            state_n = PS_EMIT;
          end
        end else begin
          state_n = PS_EMIT;
        end
      end
      PS_DONE:  state_n = PS_IDLE;
      PS_ABORT: state_n = PS_IDLE;
      default:  state_n = PS_IDLE;
    endcase
  end

  assign rd_addr     = ptr_r;
  assign print_busy  = (state_r != PS_IDLE);
  assign char_valid  = (state_r == PS_EMIT) && (cur_byte_s != 8'h00);
  assign char_data   = char_valid ? cur_byte_s : 8'h00;
  assign print_done  = (state_r == PS_DONE);
  assign print_abort = (state_r == PS_ABORT);

endmodule

// File: rtl/unified_memory_v2.sv
// Unified instruction/data memory: async fetch and load ports, byte-enabled synchronous store,
// big-endian byte order, plus an optional string-print engine reading the same array.
module unified_memory_v2
  import unified_memory_v2_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter string       INIT_FILE   = "",
  parameter int unsigned MAX_STR     = 256,
  parameter bit          PRINT_EN    = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_pc,
  output logic [31:0] instr_out,
  input  logic [31:0] data_addr,
  input  logic [1:0]  data_size,
  input  logic        data_signed,
  input  logic        data_mem_read,
  input  logic        data_mem_write,
  input  logic [31:0] data_write_data,
  output logic [31:0] data_read_data,
  output logic        data_fault,
  input  logic        print_start,
  input  logic [31:0] print_addr,
  output logic        print_busy,
  output logic        char_valid,
  output logic [7:0]  char_data,
  input  logic        char_ready,
  output logic        print_done,
  output logic        print_abort
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  logic [31:0] mem_r [DEPTH_WORDS];

  logic        range_ok_s, misalign_s;
  logic [3:0]  be_s;
  logic [31:0] wdata_s, rd_word_s;
  logic [7:0]  ld_byte_s;
  logic [15:0] ld_half_s;

  // Instruction fetch; the low two pc bits are simply dropped.
  always_comb begin
    if (word_in_range(instr_pc, DEPTH_WORDS)) begin
      instr_out = mem_r[instr_pc[AW+1:2]];
    end else begin
      instr_out = 32'h0000_0000;
    end
  end

  // Alignment, range fault and store lane decode (be_s bit 3 is big-endian byte 0).
  always_comb begin
    range_ok_s = word_in_range(data_addr, DEPTH_WORDS);
    case (data_size)
      SIZE_BYTE: begin
        misalign_s = 1'b0;
        be_s       = 4'b1000 >> data_addr[1:0];
        wdata_s    = {4{data_write_data[7:0]}};
      end
      SIZE_HALF: begin
        misalign_s = data_addr[0];
        be_s       = data_addr[1] ? 4'b0011 : 4'b1100;
        wdata_s    = {2{data_write_data[15:0]}};
      end
      default: begin
        misalign_s = (data_addr[1:0] != 2'b00);
        be_s       = 4'b1111;
        wdata_s    = data_write_data;
      end
    endcase
    data_fault = (data_mem_read | data_mem_write) & (misalign_s | ~range_ok_s);
  end

  // Storage is deliberately outside reset so preloaded images survive it.
  always @(posedge clk) begin
    if (data_mem_write && !data_fault) begin
      for (int i = 0; i < 4; i++) begin
        if (be_s[i]) begin
          mem_r[data_addr[AW+1:2]][8*i +: 8] <= wdata_s[8*i +: 8];
        end
      end
    end
  end

  // Load align and extend; old contents are visible during a same-cycle store.
  always_comb begin
    if (range_ok_s) begin
      rd_word_s = mem_r[data_addr[AW+1:2]];
    end else begin
      rd_word_s = 32'h0000_0000;
    end
    ld_byte_s = word_byte(rd_word_s, data_addr[1:0]);
    ld_half_s = data_addr[1] ? rd_word_s[15:0] : rd_word_s[31:16];
    case (data_size)
      SIZE_BYTE: data_read_data = {{24{data_signed & ld_byte_s[7]}}, ld_byte_s};
      SIZE_HALF: data_read_data = {{16{data_signed & ld_half_s[15]}}, ld_half_s};
      default:   data_read_data = rd_word_s;
    endcase
  end

  if (PRINT_EN) begin : g_print
    logic [31:0] pe_addr_s, pe_word_s;

    // Read-only port for the print engine.
    always_comb begin
      if (word_in_range(pe_addr_s, DEPTH_WORDS)) begin
        pe_word_s = mem_r[pe_addr_s[AW+1:2]];
      end else begin
        pe_word_s = 32'h0000_0000;
      end
    end

    string_print_engine #(
      .DEPTH_WORDS(DEPTH_WORDS),
      .MAX_STR    (MAX_STR)
    ) u_engine (
      .clk        (clk),
      .reset      (reset),
      .print_start(print_start),
      .print_addr (print_addr),
      .char_ready (char_ready),
      .rd_word    (pe_word_s),
      .rd_addr    (pe_addr_s),
      .print_busy (print_busy),
      .char_valid (char_valid),
      .char_data  (char_data),
      .print_done (print_done),
      .print_abort(print_abort)
    );
  end else begin : g_no_print
    assign print_busy  = 1'b0;
    assign char_valid  = 1'b0;
    assign char_data   = 8'h00;
    assign print_done  = 1'b0;
    assign print_abort = 1'b0;
  end

endmodule

// File: tb/tb_unified_memory_v2.sv
// Directed self-checking bench for unified_memory_v2: loads/stores, faults and the print engine.
module tb_unified_memory_v2;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_pc, instr_out;
  logic [31:0] data_addr, data_write_data, data_read_data;
  logic [1:0]  data_size;
  logic        data_signed, data_mem_read, data_mem_write, data_fault;
  logic        print_start, print_busy, char_valid, char_ready, print_done, print_abort;
  logic [31:0] print_addr;
  logic [7:0]  char_data;

  // Second instance with a 4-character limit.
  logic [31:0] instr_out_l, data_addr_l, data_write_data_l, data_read_data_l;
  logic [1:0]  data_size_l;
  logic        data_mem_write_l, data_fault_l;
  logic        print_start_l, print_busy_l, char_valid_l, char_ready_l, print_done_l, print_abort_l;
  logic [7:0]  char_data_l;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  unified_memory_v2 u_dut (
    .clk(clk), .reset(reset), .instr_pc(instr_pc), .instr_out(instr_out),
    .data_addr(data_addr), .data_size(data_size), .data_signed(data_signed),
    .data_mem_read(data_mem_read), .data_mem_write(data_mem_write),
    .data_write_data(data_write_data), .data_read_data(data_read_data), .data_fault(data_fault),
    .print_start(print_start), .print_addr(print_addr), .print_busy(print_busy),
    .char_valid(char_valid), .char_data(char_data), .char_ready(char_ready),
    .print_done(print_done), .print_abort(print_abort)
  );

  unified_memory_v2 #(.DEPTH_WORDS(64), .MAX_STR(4)) u_dut_lim (
    .clk(clk), .reset(reset), .instr_pc(32'h0000_0000), .instr_out(instr_out_l),
    .data_addr(data_addr_l), .data_size(data_size_l), .data_signed(1'b0),
    .data_mem_read(1'b0), .data_mem_write(data_mem_write_l),
    .data_write_data(data_write_data_l), .data_read_data(data_read_data_l), .data_fault(data_fault_l),
    .print_start(print_start_l), .print_addr(32'h0000_0000), .print_busy(print_busy_l),
    .char_valid(char_valid_l), .char_data(char_data_l), .char_ready(char_ready_l),
    .print_done(print_done_l), .print_abort(print_abort_l)
  );

  task automatic store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    @(negedge clk);
    data_addr = a; data_size = sz; data_write_data = d; data_mem_write = 1'b1; data_mem_read = 1'b0;
    @(negedge clk);
    data_mem_write = 1'b0;
  endtask

  task automatic store_l(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    data_addr_l = a; data_size_l = 2'b10; data_write_data_l = d; data_mem_write_l = 1'b1;
    @(negedge clk);
    data_mem_write_l = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, input logic [1:0] sz, input logic sgn);
    @(negedge clk);
    data_addr = a; data_size = sz; data_signed = sgn; data_mem_read = 1'b1; data_mem_write = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    logic stray;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    total++;
    if ({print_busy, char_valid, char_data, print_done, print_abort, data_fault} !== 13'h0) begin
      bad++;
      $display("FAIL reset_idle: got %b expected all zero",
               {print_busy, char_valid, char_data, print_done, print_abort, data_fault});
    end
    store(32'h0000_0000, 2'b10, 32'hDEAD_BEEF);
    store(32'h0000_0040, 2'b10, 32'h4869_2100);
    @(negedge clk);
    print_addr = 32'h0000_0040; print_start = 1'b1; char_ready = 1'b0;
    @(negedge clk);
    print_start = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (print_busy !== 1'b1 || char_valid !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset_busy: busy=%b valid=%b expected 1 1", print_busy, char_valid);
    end
    reset = 1'b1;
    #1;
    total++;
    if ({print_busy, char_valid, char_data, print_done, print_abort} !== 12'h0) begin
      bad++;
      $display("FAIL reset_mid_print: got %b expected all zero",
               {print_busy, char_valid, char_data, print_done, print_abort});
    end
    @(negedge clk);
    reset = 1'b0;
    stray = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (print_busy || print_done || print_abort || char_valid) stray = 1'b1;
    end
    total++;
    if (stray !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_quiet: activity seen=%b expected 0", stray);
    end
    load(32'h0000_0000, 2'b10, 1'b0);
    total++;
    if (data_read_data !== 32'hDEAD_BEEF) begin
      bad++;
      $display("FAIL mem_persist: got %h expected deadbeef", data_read_data);
    end
    instr_pc = 32'h0000_0002;
    #1;
    total++;
    if (instr_out !== 32'hDEAD_BEEF) begin
      bad++;
      $display("FAIL instr_trunc: got %h expected deadbeef", instr_out);
    end
    data_mem_read = 1'b0;
  endtask

  task automatic test_load_store();
    store(32'h0000_0010, 2'b10, 32'h5566_7788);
    @(negedge clk);
    data_addr = 32'h0000_0010; data_size = 2'b10; data_write_data = 32'h1122_3344;
    data_mem_write = 1'b1;
    #1;
    total++;
    if (data_read_data !== 32'h5566_7788 || data_fault !== 1'b0) begin
      bad++;
      $display("FAIL rdw_old: got %h fault=%b expected 55667788 0", data_read_data, data_fault);
    end
    @(negedge clk);
    data_mem_write = 1'b0;
    #1;
    total++;
    if (data_read_data !== 32'h1122_3344) begin
      bad++;
      $display("FAIL rdw_new: got %h expected 11223344", data_read_data);
    end
    store(32'h0000_0012, 2'b00, 32'h0000_00AA);
    load(32'h0000_0010, 2'b01, 1'b1);
    total++;
    if (data_read_data !== 32'h0000_1122) begin
      bad++;
      $display("FAIL lh_s_10: got %h expected 00001122", data_read_data);
    end
    load(32'h0000_0012, 2'b00, 1'b1);
    total++;
    if (data_read_data !== 32'hFFFF_FFAA) begin
      bad++;
      $display("FAIL lb_s_12: got %h expected ffffffaa", data_read_data);
    end
    load(32'h0000_0012, 2'b00, 1'b0);
    total++;
    if (data_read_data !== 32'h0000_00AA) begin
      bad++;
      $display("FAIL lbu_12: got %h expected 000000aa", data_read_data);
    end
    load(32'h0000_0012, 2'b01, 1'b1);
    total++;
    if (data_read_data !== 32'hFFFF_AA44) begin
      bad++;
      $display("FAIL lh_s_12: got %h expected ffffaa44", data_read_data);
    end
    load(32'h0000_0010, 2'b10, 1'b0);
    total++;
    if (data_read_data !== 32'h1122_AA44) begin
      bad++;
      $display("FAIL lw_10: got %h expected 1122aa44", data_read_data);
    end
    data_mem_read = 1'b0;
  endtask

  task automatic test_faults();
    @(negedge clk);
    data_addr = 32'h0000_0011; data_size = 2'b10; data_write_data = 32'hFFFF_FFFF;
    data_mem_write = 1'b1;
    #1;
    total++;
    if (data_fault !== 1'b1) begin
      bad++;
      $display("FAIL sw_misalign_fault: got %b expected 1", data_fault);
    end
    @(negedge clk);
    data_mem_write = 1'b0;
    load(32'h0000_0010, 2'b10, 1'b0);
    total++;
    if (data_read_data !== 32'h1122_AA44) begin
      bad++;
      $display("FAIL sw_misalign_dropped: got %h expected 1122aa44", data_read_data);
    end
    load(32'h0000_0013, 2'b01, 1'b1);
    total++;
    if (data_fault !== 1'b1) begin
      bad++;
      $display("FAIL lh_misalign_fault: got %b expected 1", data_fault);
    end
    data_mem_read = 1'b0;
    #1;
    total++;
    if (data_fault !== 1'b0) begin
      bad++;
      $display("FAIL fault_needs_access: got %b expected 0", data_fault);
    end
    @(negedge clk);
    data_addr = 32'h0000_1000; data_size = 2'b10; data_write_data = 32'h1234_5678;
    data_mem_write = 1'b1;
    #1;
    total++;
    if (data_fault !== 1'b1) begin
      bad++;
      $display("FAIL oor_store_fault: got %b expected 1", data_fault);
    end
    @(negedge clk);
    data_mem_write = 1'b0;
    load(32'h0000_1000, 2'b10, 1'b0);
    total++;
    if (data_read_data !== 32'h0000_0000 || data_fault !== 1'b1) begin
      bad++;
      $display("FAIL oor_read: got %h fault=%b expected 00000000 1", data_read_data, data_fault);
    end
    load(32'h0000_0000, 2'b10, 1'b0);
    total++;
    if (data_read_data !== 32'hDEAD_BEEF) begin
      bad++;
      $display("FAIL oor_no_alias: got %h expected deadbeef", data_read_data);
    end
    load(32'h0000_0FFC, 2'b10, 1'b0);
    total++;
    if (data_fault !== 1'b0) begin
      bad++;
      $display("FAIL last_word_ok: fault=%b expected 0", data_fault);
    end
    data_mem_read = 1'b0;
  endtask

  task automatic test_print_basic();
    logic [11:0] exp_v, got_v;
    store(32'h0000_0040, 2'b10, 32'h4869_2100);
    @(negedge clk);
    print_addr = 32'h0000_0040; print_start = 1'b1; char_ready = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      print_start = 1'b0;
      case (c)
        1:       exp_v = {1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
        2:       exp_v = {1'b1, 1'b1, 8'h48, 1'b0, 1'b0};
        3:       exp_v = {1'b1, 1'b1, 8'h69, 1'b0, 1'b0};
        4:       exp_v = {1'b1, 1'b1, 8'h21, 1'b0, 1'b0};
        5:       exp_v = {1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
        default: exp_v = 12'h000;
      endcase
      got_v = {print_busy, char_valid, (char_valid ? char_data : 8'h00), print_done, print_abort};
      total++;
      if (got_v !== exp_v) begin
        bad++;
        $display("FAIL print_hi_cycle%0d: busy/valid/char/done/abort got %h expected %h", c, got_v, exp_v);
      end
    end
    char_ready = 1'b0;
  endtask

  task automatic test_print_span();
    logic [39:0] exp_s;
    logic [7:0]  got[$];
    logic [7:0]  last_data;
    logic        last_hold, bubble_next, done_seen;
    exp_s = "ABCDE";
    store(32'h0000_0040, 2'b10, 32'h0000_4142);
    store(32'h0000_0044, 2'b10, 32'h4344_4500);
    @(negedge clk);
    print_addr = 32'h0000_0042; print_start = 1'b1; char_ready = 1'b0;
    last_hold = 1'b0; bubble_next = 1'b0; done_seen = 1'b0; last_data = 8'h00;
    for (int c = 1; c < 40 && !done_seen; c++) begin
      @(negedge clk);
      print_start = 1'b0;
      if (last_hold) begin
        total++;
        if (char_valid !== 1'b1 || char_data !== last_data) begin
          bad++;
          $display("FAIL span_hold c%0d: valid=%b char=%h expected 1 %h", c, char_valid, char_data, last_data);
        end
      end
      if (bubble_next) begin
        total++;
        if (char_valid !== 1'b0 || print_busy !== 1'b1) begin
          bad++;
          $display("FAIL span_bubble c%0d: valid=%b busy=%b expected 0 1", c, char_valid, print_busy);
        end
      end
      bubble_next = 1'b0;
      if (print_done === 1'b1) done_seen = 1'b1;
      char_ready = ((c % 3) != 0);
      last_hold  = char_valid && !char_ready;
      last_data  = char_data;
      if (char_valid === 1'b1 && char_ready === 1'b1) begin
        got.push_back(char_data);
        if (char_data === 8'h42) bubble_next = 1'b1;
      end
    end
    char_ready = 1'b0;
    total++;
    if (done_seen !== 1'b1) begin
      bad++;
      $display("FAIL span_done: seen=%b expected 1 within budget", done_seen);
    end
    total++;
    if (got.size() != 5) begin
      bad++;
      $display("FAIL span_count: got %0d chars expected 5", got.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        total++;
        if (got[i] !== exp_s[39-8*i -: 8]) begin
          bad++;
          $display("FAIL span_char%0d: got %h expected %h", i, got[i], exp_s[39-8*i -: 8]);
        end
      end
    end
    @(negedge clk);
    total++;
    if (print_busy !== 1'b0) begin
      bad++;
      $display("FAIL span_idle: busy=%b expected 0", print_busy);
    end
  endtask

  task automatic test_print_limit();
    logic [31:0] exp_s;
    logic [7:0]  got[$];
    int          aborts, dones;
    exp_s = "ABCD";
    store_l(32'h0000_0000, 32'h4142_4344);
    store_l(32'h0000_0004, 32'h4546_4748);
    store_l(32'h0000_0008, 32'h494A_4B4C);
    @(negedge clk);
    print_start_l = 1'b1; char_ready_l = 1'b1;
    aborts = 0; dones = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      print_start_l = 1'b0;
      if (print_abort_l === 1'b1) aborts++;
      if (print_done_l === 1'b1) dones++;
      if (char_valid_l === 1'b1) got.push_back(char_data_l);
    end
    total++;
    if (got.size() != 4) begin
      bad++;
      $display("FAIL limit_count: got %0d chars expected 4", got.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (got[i] !== exp_s[31-8*i -: 8]) begin
          bad++;
          $display("FAIL limit_char%0d: got %h expected %h", i, got[i], exp_s[31-8*i -: 8]);
        end
      end
    end
    total++;
    if (aborts != 1 || dones != 0) begin
      bad++;
      $display("FAIL limit_pulses: abort=%0d done=%0d expected 1 0", aborts, dones);
    end
    total++;
    if (print_busy_l !== 1'b0) begin
      bad++;
      $display("FAIL limit_idle: busy=%b expected 0", print_busy_l);
    end
    char_ready_l = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    instr_pc = 32'h0000_0000;
    data_addr = 32'h0000_0000; data_size = 2'b10; data_signed = 1'b0;
    data_mem_read = 1'b0; data_mem_write = 1'b0; data_write_data = 32'h0000_0000;
    print_start = 1'b0; print_addr = 32'h0000_0000; char_ready = 1'b0;
    data_addr_l = 32'h0000_0000; data_size_l = 2'b10; data_write_data_l = 32'h0000_0000;
    data_mem_write_l = 1'b0; print_start_l = 1'b0; char_ready_l = 1'b0;
    test_reset();
    test_load_store();
    test_faults();
    test_print_basic();
    test_print_span();
    test_print_limit();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
